div_issue_ctrl: RTL and testbench

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Integer divide issue controller: accepts DIV/DIVU/REM/REMU, resolves trivial
// cases and repeat operands locally, otherwise launches an external divider core
// on operand magnitudes and sign-corrects its result before writeback.
module div_issue_ctrl #(
  parameter int DIV_WIDTH = 32,
  parameter int ID_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [DIV_WIDTH-1:0]         rs1,
  input  logic [DIV_WIDTH-1:0]         rs2,
  input  logic [1:0]                   op,
  input  logic [ID_W-1:0]              id,
  output logic                         wb_valid,
  input  logic                         wb_ack,
  output logic [DIV_WIDTH-1:0]         wb_rd,
  output logic [ID_W-1:0]              wb_id,
  output logic                         core_start,
  output logic [DIV_WIDTH-1:0]         core_dividend,
  output logic [DIV_WIDTH-1:0]         core_divisor,
  output logic [$clog2(DIV_WIDTH)-1:0] core_dividend_clz,
  output logic [$clog2(DIV_WIDTH)-1:0] core_divisor_clz,
  input  logic                         core_done,
  input  logic [DIV_WIDTH-1:0]         core_quotient,
  input  logic [DIV_WIDTH-1:0]         core_remainder
);

  localparam int CW = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_e;

  // Leading-zero count; a zero input wraps, but zero magnitudes never take the slow path.
  function automatic logic [CW-1:0] clz(input logic [DIV_WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = DIV_WIDTH - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + CW'(1);
      else                 found = 1'b1;
    end
    return n;
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DIV_WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DIV_WIDTH-1:0]  mag1_q, mag1_d, mag2_q, mag2_d;
  logic                  neg1_q, neg1_d, neg2_q, neg2_d;
  logic [DIV_WIDTH-1:0]  res_q, res_d;
  // Reuse cache: last core-computed operands and their corrected results.
  logic                  cache_vld_q, cache_vld_d;
  logic [DIV_WIDTH-1:0]  c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
  logic                  c_uns_q, c_uns_d;
  logic [DIV_WIDTH-1:0]  c_quo_q, c_quo_d, c_rem_q, c_rem_d;

  logic                  accept;
  logic                  in_neg1, in_neg2;
  logic [DIV_WIDTH-1:0]  in_mag1, in_mag2;
  logic                  hit, fast;
  logic [DIV_WIDTH-1:0]  fast_res;
  logic [DIV_WIDTH-1:0]  quo_c, rem_c;

  assign issue_ready       = (state_q == IDLE) && !flush;
  assign accept            = issue_valid && issue_ready;
  assign wb_valid          = (state_q == WB) && !flush;
  assign wb_rd             = res_q;
  assign wb_id             = id_q;
  assign core_start        = (state_q == START);
  assign core_dividend     = mag1_q;
  assign core_divisor      = mag2_q;
  assign core_dividend_clz = clz(mag1_q);
  assign core_divisor_clz  = clz(mag2_q);

  // Operand decode at issue: sign flags, magnitudes and the local fast-path result.
  always_comb begin
    in_neg1  = !op[0] && rs1[DIV_WIDTH-1];
    in_neg2  = !op[0] && rs2[DIV_WIDTH-1];
    in_mag1  = in_neg1 ? -rs1 : rs1;
    in_mag2  = in_neg2 ? -rs2 : rs2;
    hit      = cache_vld_q && (rs1 == c_rs1_q) && (rs2 == c_rs2_q) && (op[0] == c_uns_q);
    fast     = (rs2 == '0) || (rs1 == '0) || hit;
    fast_res = '0;
    if (rs2 == '0)      fast_res = op[1] ? rs1 : '1;
    else if (rs1 == '0) fast_res = '0;
    else                fast_res = op[1] ? c_rem_q : c_quo_q;
  end

  // Sign correction of the raw core result (unsigned magnitudes in, signed out).
  always_comb begin
    quo_c = (!op_q[0] && (neg1_q != neg2_q)) ? -core_quotient : core_quotient;
    rem_c = (!op_q[0] && neg1_q) ? -core_remainder : core_remainder;
  end

  // Next-state and datapath update; flush overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    id_d        = id_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    mag1_d      = mag1_q;
    mag2_d      = mag2_q;
    neg1_d      = neg1_q;
    neg2_d      = neg2_q;
    res_d       = res_q;
    cache_vld_d = cache_vld_q;
    c_rs1_d     = c_rs1_q;
    c_rs2_d     = c_rs2_q;
    c_uns_d     = c_uns_q;
    c_quo_d     = c_quo_q;
    c_rem_d     = c_rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op;
          id_d   = id;
          rs1_d  = rs1;
          rs2_d  = rs2;
          mag1_d = in_mag1;
          mag2_d = in_mag2;
          neg1_d = in_neg1;
          neg2_d = in_neg2;
          if (fast) begin
            res_d   = fast_res;
            state_d = WB;
          end else begin
            state_d = START;
          end
        end
      end
      START, BUSY: begin
        if (core_done) begin
          res_d       = op_q[1] ? rem_c : quo_c;
          cache_vld_d = 1'b1;
          c_rs1_d     = rs1_q;
          c_rs2_d     = rs2_q;
          c_uns_d     = op_q[0];
          c_quo_d     = quo_c;
          c_rem_d     = rem_c;
          state_d     = WB;
        end else begin
          state_d = BUSY;
        end
      end
      WB: begin
        if (wb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      cache_vld_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  // Datapath registers; only meaningful when qualified by state or cache valid.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    id_q    <= id_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    mag1_q  <= mag1_d;
    mag2_q  <= mag2_d;
    neg1_q  <= neg1_d;
    neg2_q  <= neg2_d;
    res_q   <= res_d;
    c_rs1_q <= c_rs1_d;
    c_rs2_q <= c_rs2_d;
    c_uns_q <= c_uns_d;
    c_quo_q <= c_quo_d;
    c_rem_q <= c_rem_d;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: driver pushes expected results, a monitor
// checks every writeback; a behavioural divider core answers core_start.
module tb_div_issue_ctrl;
  localparam int W  = 32;
  localparam int IW = 3;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, issue_valid = 1'b0;
  logic [W-1:0]  rs1 = '0, rs2 = '0;
  logic [1:0]    op = '0;
  logic [IW-1:0] id = '0;
  logic          wb_ack = 1'b0, core_done = 1'b0;
  logic [W-1:0]  core_quotient = '0, core_remainder = '0;
  logic          issue_ready, wb_valid, core_start;
  logic [W-1:0]  wb_rd, core_dividend, core_divisor;
  logic [IW-1:0] wb_id;
  logic [4:0]    core_dividend_clz, core_divisor_clz;

  div_issue_ctrl #(.DIV_WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .op(op), .id(id),
    .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_rd(wb_rd), .wb_id(wb_id),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_dividend_clz(core_dividend_clz), .core_divisor_clz(core_divisor_clz),
    .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a, b, rd;
    logic [IW-1:0] id;
    int            acc, lat, starts;
    bit            slow, seen;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0, n_err = 0;
  int            cyc = 0, core_lat = 1, ack_hold = 0, starts = 0, hold_cnt = 0, cnt = -1;
  bit            cvld = 1'b0, chk_ready_next = 1'b0;
  logic [W-1:0]  ca = '0, cb = '0, pq = '0, pr = '0;
  logic          cop0 = 1'b0;
  logic [IW-1:0] next_id = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result from the instruction definition, using wide signed math.
  function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sbv, q, r;
    if (b == '0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? (a % b) : (a / b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    q   = sa / sbv;
    r   = sa % sbv;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [W-1:0] magn(input logic [1:0] o, input logic [W-1:0] v);
    return (!o[0] && v[W-1]) ? -v : v;
  endfunction

  function automatic logic [W-1:0] lz(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return W - 1 - i;
    return W;
  endfunction

  always @(posedge clk) cyc++;

  // Divider core model: answers core_start after core_lat cycles (0 = same cycle).
  always @(posedge clk) begin
    #1;
    core_done = 1'b0;
    if (core_start) begin
      starts++;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_core_start at cycle %0d", cyc);
      end else begin
        check("core_dividend", core_dividend, magn(sb[0].op, sb[0].a));
        check("core_divisor", core_divisor, magn(sb[0].op, sb[0].b));
        check("dividend_clz", {27'd0, core_dividend_clz}, lz(magn(sb[0].op, sb[0].a)));
        check("divisor_clz", {27'd0, core_divisor_clz}, lz(magn(sb[0].op, sb[0].b)));
      end
      pq  = (core_divisor == '0) ? '1 : core_dividend / core_divisor;
      pr  = (core_divisor == '0) ? core_dividend : core_dividend % core_divisor;
      cnt = core_lat;
    end else if (cnt >= 0) begin
      cnt--;
    end
    if (cnt == 0) begin
      core_done      = 1'b1;
      core_quotient  = pq;
      core_remainder = pr;
    end else begin
      core_quotient  = $urandom;
      core_remainder = $urandom;
    end
  end

  // Writeback acceptor: holds off wb_ack for ack_hold valid cycles.
  always @(posedge clk) begin
    #1;
    if (wb_valid) begin
      wb_ack = (hold_cnt >= ack_hold);
      hold_cnt++;
    end else begin
      wb_ack   = 1'b0;
      hold_cnt = 0;
    end
  end

  // Monitor: compares every presented writeback against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_ready_next) begin
        chk_ready_next = 1'b0;
        if (!flush) check("ready_after_ack", {31'd0, issue_ready}, 32'd1);
      end
      if (wb_valid) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_wb_valid: got wb_rd 0x%08h with nothing outstanding (cycle %0d)", wb_rd, cyc);
        end else begin
          if (!sb[0].seen) begin
            sb[0].seen = 1'b1;
            check("wb_latency", cyc - sb[0].acc, sb[0].lat);
          end
          check("wb_rd", wb_rd, sb[0].rd);
          check("wb_id", {29'd0, wb_id}, {29'd0, sb[0].id});
          check("ready_in_wb", {31'd0, issue_ready}, 32'd0);
          if (wb_ack) begin
            check("core_start_count", starts - sb[0].starts, sb[0].slow ? 1 : 0);
            void'(sb.pop_front());
            chk_ready_next = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   got, hit;
    @(posedge clk); #1;
    op = o; rs1 = a; rs2 = b; id = next_id; issue_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (issue_ready) got = 1'b1;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: issue_ready stayed 0, required 1 (cycle %0d)", cyc);
    end else begin
      hit      = cvld && (ca == a) && (cb == b) && (cop0 == o[0]);
      e.op     = o; e.a = a; e.b = b; e.id = next_id;
      e.rd     = ref_res(o, a, b);
      e.slow   = !((b == '0) || (a == '0) || hit);
      e.acc    = cyc;
      e.lat    = e.slow ? 2 + core_lat : 1;
      e.starts = starts;
      e.seen   = 1'b0;
      sb.push_back(e);
      if (e.slow) begin cvld = 1'b1; ca = a; cb = b; cop0 = o[0]; end
      next_id++;
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_op(o, a, b);
    drain();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(1, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s0;
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Slow path then cache hit on the other half of the same operands.
    core_lat = 3;
    run(2'b01, 32'd100, 32'd7);
    run(2'b11, 32'd100, 32'd7);
    // Signed with an intervening different divisor so REM takes the core.
    run(2'b00, 32'hFFFF_FFF9, 32'd2);
    run(2'b00, 32'hFFFF_FFF9, 32'd3);
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    // Signed overflow.
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    // Divide by zero, zero dividend.
    run(2'b01, 32'd5, 32'd0);
    run(2'b10, 32'd5, 32'd0);
    run(2'b00, 32'd0, 32'd9);
    // Core done in the START cycle.
    core_lat = 0;
    run(2'b01, 32'd3, 32'd9);
    // Writeback stall.
    ack_hold = 5; core_lat = 2;
    run(2'b01, 32'd1000, 32'd3);
    ack_hold = 0;

    // Flush while BUSY, with a late core_done after it.
    core_lat = 8;
    issue_op(2'b01, 32'd77, 32'd5);
    @(posedge clk); #1;
    flush = 1'b1; issue_valid = 1'b1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd4;
    @(negedge clk);
    check("flush_blocks_issue", {31'd0, issue_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; issue_valid = 1'b0;
    sb.delete(); cvld = 1'b0;
    @(negedge clk);
    check("ready_after_flush", {31'd0, issue_ready}, 32'd1);
    check("no_wb_after_flush", {31'd0, wb_valid}, 32'd0);
    repeat (12) @(negedge clk);
    // Flush in IDLE must not accept a concurrent issue.
    s0 = starts;
    @(posedge clk); #1;
    flush = 1'b1; issue_valid = 1'b1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd4;
    @(posedge clk); #1;
    flush = 1'b0; issue_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_flush_no_start", starts, s0);
    // Cache was invalidated: this must go back to the core.
    core_lat = 1;
    run(2'b01, 32'd1000, 32'd3);

    // Reset mid-operation drops the op and the cache.
    core_lat = 6;
    issue_op(2'b01, 32'd123, 32'd4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete(); cvld = 1'b0;
    @(negedge clk);
    check("midrst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (10) @(negedge clk);
    core_lat = 2;
    run(2'b01, 32'd123, 32'd4);

    // Randomized mix with deliberate operand repeats to exercise the cache.
    ra = 32'd1; rb = 32'd1;
    repeat (80) begin
      core_lat = $urandom_range(0, 4);
      ack_hold = $urandom_range(0, 2);
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        ra = pick();
        rb = pick();
      end
      run(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
